// File: rtl/deser_demux_1x4_pkg.sv
// Shared constants and helpers for the serial-to-parallel demux.
package deser_demux_1x4_pkg;

    localparam int N_DEF = 4;

    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int idx_last(input int n);
        return n - 1;
    endfunction

    localparam int LAST_DEF = idx_last(N_DEF);

endpackage

// File: rtl/deser_demux_1x4_if.sv
// Parallel word handshake between the demux and its consumer.
interface deser_demux_1x4_if
    import deser_demux_1x4_pkg::*;
#(
    parameter int N = N_DEF
);

    logic [N-1:0] word_out;
    logic         word_valid;
    logic         word_ready;

    modport master (
        output word_out,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/deser_demux_1x4_reg.sv
// One-hot write decoder plus shadow bit array for the lower word positions.
module demux_1xN_reg
    import deser_demux_1x4_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int IDX_W = idx_w(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDX_W-1:0] idx,
    input  logic             d,
    output logic [N-2:0]     shadow
);

    logic [N-2:0] sel;

    // The top position bypasses the array and goes straight into the word.
    always_comb begin
        sel = '0;
        for (int i = 0; i < N - 1; i++) begin
            sel[i] = we && (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else begin
            for (int i = 0; i < N - 1; i++) begin
                if (sel[i]) begin
                    shadow[i] <= d;
                end
            end
        end
    end

endmodule

// File: rtl/deser_demux_1x4.sv
// Serial-to-parallel demux: steers one bit per valid cycle into word[idx],
// presenting completed words through a registered valid/ready slot.
module deser_demux_1x4
    import deser_demux_1x4_pkg::*;
#(
    parameter  int N     = N_DEF,
    localparam int IDX_W = idx_w(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_in,
    input  logic               bit_valid,
    input  logic               sync,
    deser_demux_1x4_if.master  wbus,
    output logic [IDX_W-1:0]   idx,
    output logic               overrun,
    input  logic               clr_overrun
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(idx_last(N));

    logic [IDX_W-1:0] pos;
    logic [N-2:0]     shadow;
    logic [N-1:0]     word;
    logic [N-1:0]     word_q;
    logic             valid_q;
    logic             complete;
    logic             slot_free;

    assign pos       = sync ? '0 : idx;
    assign complete  = bit_valid && (pos == LAST);
    assign word      = {bit_in, shadow};
    assign slot_free = !valid_q || wbus.word_ready;

    demux_1xN_reg #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_reg (
        .clk    (clk),
        .rst    (rst),
        .we     (bit_valid),
        .idx    (pos),
        .d      (bit_in),
        .shadow (shadow)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (bit_valid) begin
            idx <= (pos == LAST) ? '0 : pos + IDX_W'(1);
        end else if (sync) begin
            idx <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q  <= '0;
            valid_q <= 1'b0;
        end else if (complete && slot_free) begin
            word_q  <= word;
            valid_q <= 1'b1;
        end else if (valid_q && wbus.word_ready) begin
            valid_q <= 1'b0;
        end
    end

    // A drop on the same edge as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (complete && !slot_free) begin
            overrun <= 1'b1;
        end else if (clr_overrun) begin
            overrun <= 1'b0;
        end
    end

    assign wbus.word_out   = word_q;
    assign wbus.word_valid = valid_q;

endmodule

// File: tb/tb_deser_demux_1x4.sv
// Directed bench for deser_demux_1x4 with hand-computed expected words.
module tb_deser_demux_1x4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       sync = 1'b0;
    logic       clr_overrun = 1'b0;
    logic [1:0] idx;
    logic       overrun;
    int         total = 0;
    int         bad = 0;

    deser_demux_1x4_if #(.N(4)) wif ();

    deser_demux_1x4 #(.N(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bit_in      (bit_in),
        .bit_valid   (bit_valid),
        .sync        (sync),
        .wbus        (wif),
        .idx         (idx),
        .overrun     (overrun),
        .clr_overrun (clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // drive on the falling edge, leave outputs settled 1ns after rising
    task automatic step(input logic bv, input logic b, input logic s,
                        input logic clr);
        @(negedge clk);
        bit_valid   = bv;
        bit_in      = b;
        sync        = s;
        clr_overrun = clr;
        @(posedge clk);
        #1;
        bit_valid   = 1'b0;
        sync        = 1'b0;
        clr_overrun = 1'b0;
    endtask

    task automatic send4(input logic [3:0] w);
        for (int i = 0; i < 4; i++) step(1'b1, w[i], 1'b0, 1'b0);
    endtask

    logic [3:0] v;

    initial begin
        wif.word_ready = 1'b1;
        #12;
        chk("rst_idx", 32'(idx), 0);
        chk("rst_wv", 32'(wif.word_valid), 0);
        chk("rst_wo", 32'(wif.word_out), 0);
        chk("rst_ov", 32'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;

        // reset in the middle of a word
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mid_idx", 32'(idx), 2);
        rst = 1'b1;
        #2;
        chk("mrst_idx", 32'(idx), 0);
        chk("mrst_wv", 32'(wif.word_valid), 0);
        chk("mrst_wo", 32'(wif.word_out), 0);
        chk("mrst_ov", 32'(overrun), 0);
        @(negedge clk);
        rst = 1'b0;
        send4(4'b1101);
        chk("w1101_wv", 32'(wif.word_valid), 1);
        chk("w1101_wo", 32'(wif.word_out), 32'h d);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("w1101_take", 32'(wif.word_valid), 0);

        // streaming, ready held high
        v = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) v = 4'b1111;
            step(1'b1, v[i % 4], 1'b0, 1'b0);
            chk("strm_wv", 32'(wif.word_valid), 32'((i == 3) || (i == 7)));
            if (i == 3) chk("strm_w0", 32'(wif.word_out), 32'h6);
            if (i == 7) chk("strm_w1", 32'(wif.word_out), 32'hf);
        end
        chk("strm_ov", 32'(overrun), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // backpressure drop
        wif.word_ready = 1'b0;
        send4(4'b0001);
        chk("bp_wv0", 32'(wif.word_valid), 1);
        chk("bp_wo0", 32'(wif.word_out), 32'h1);
        send4(4'b1010);
        chk("drop_wo", 32'(wif.word_out), 32'h1);
        chk("drop_wv", 32'(wif.word_valid), 1);
        chk("drop_ov", 32'(overrun), 1);
        chk("drop_idx", 32'(idx), 0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_ov", 32'(overrun), 0);
        chk("clr_wv", 32'(wif.word_valid), 1);

        // drop and clear on the same edge: set wins
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        chk("setwin_ov", 32'(overrun), 1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("setwin_clr", 32'(overrun), 0);

        // consume and complete on the same edge
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sim_hold", 32'(wif.word_out), 32'h1);
        wif.word_ready = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("sim_wo", 32'(wif.word_out), 32'ha);
        chk("sim_wv", 32'(wif.word_valid), 1);
        chk("sim_ov", 32'(overrun), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sim_take", 32'(wif.word_valid), 0);

        // sync resync
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("sync_idx", 32'(idx), 1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sync_wo", 32'(wif.word_out), 32'h4);
        chk("sync_wv", 32'(wif.word_valid), 1);
        chk("sync_idx0", 32'(idx), 0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("salone_idx", 32'(idx), 0);
        chk("salone_wv", 32'(wif.word_valid), 0);
        chk("salone_ov", 32'(overrun), 0);

        // idle gaps between accepts
        v = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step(1'b0, 1'b1, 1'b0, 1'b0);
                chk("gap_idx", 32'(idx), 32'(i));
                chk("gap_wv", 32'(wif.word_valid), 0);
            end
            step(1'b1, v[i], 1'b0, 1'b0);
            chk("acc_idx", 32'((i + 1) % 4), 32'(idx));
        end
        chk("gap_wo", 32'(wif.word_out), 32'h6);
        chk("gap_wv1", 32'(wif.word_valid), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/deser_demux_1x4.md
Name: deser_demux_1x4

Overview:
- Serial-to-parallel demultiplexer; the receive-side counterpart of the 4:1 selector tree.
- Accepts one data bit per valid cycle and steers it into word position `idx` (0..N-1, LSB first), so bit k lands at word[k], matching selector code k.
- Presents each completed word on a registered output with a valid/ready handshake.
- Sits between a serial link driven by a mux-based serializer and a parallel consumer.

Parameters:
- N, 4, word width in bits / number of demux outputs; must be >= 2.
- IDX_W, $clog2(N), width of the position counter (derived; do not override).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is valid this cycle; always accepted, there is no backpressure on the serial side.
- sync  input  1  start-of-word marker; forces the position counter to 0.
- word_out  output  N  completed parallel word.
- word_valid  output  1  word_out holds an unconsumed word.
- word_ready  input  1  consumer accepts word_out when word_valid && word_ready.
- idx  output  IDX_W  current demux position; the next accepted bit is written to word[idx].
- overrun  output  1  sticky flag: a completed word was dropped.
- clr_overrun  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async assert, sync deassert): idx=0, shadow=0, word_out=0, word_valid=0, overrun=0. Any partial word is discarded.
- Accept: on a clock edge with bit_valid=1:
  - shadow[p] <= bit_in, where p = 0 if sync=1, else idx.
  - idx <= p+1, wrapping from N-1 to 0.
  - Shadow bits not yet written in the current word hold stale values. Only word_out is defined at completion.
- sync=1 with bit_valid=0: idx <= 0. The partial word is discarded with no output and no overrun.
- Completion: an accept with p = N-1.
  - The full word is {bit_in, shadow[N-2:0]}.
  - Load it if the slot is free, i.e. word_valid=0, or word_valid=1 with word_ready=1 in the same cycle. Then word_out <= word and word_valid <= 1 on the same edge.
  - Latency: word_valid is high in the cycle after the edge that accepts the last bit.
- Drop: completion while word_valid=1 and word_ready=0.
  - The new word is dropped; word_out and word_valid are unchanged.
  - overrun <= 1.
  - idx still wraps to 0.
- Handshake:
  - word_valid && word_ready with no simultaneous completion: word_valid <= 0 and word_out holds its value.
  - word_out is stable while word_valid=1 and the word is not consumed.
  - word_ready while word_valid=0 has no effect.
- overrun:
  - Set by a drop.
  - Cleared by clr_overrun=1.
  - If a drop and clr_overrun happen on the same edge, set wins (overrun=1).
- bit_valid=0 and sync=0: state holds.
- Back-to-back: continuous bit_valid with word_ready held at 1 produces one word every N cycles, with no drops.
- Implementation: all outputs are registered; there is no combinational path from any input to any output.

Decomposition:
- Shared package: the N default, the IDX_W derivation function, and the index wrap constant (N-1).
- One natural sub-module, `demux_1xN_reg`: a one-hot write-enable decoder plus a bit register array (idx, we, d -> shadow).
- The top level holds the counter, the output slot, the handshake and overrun.

Test Plan:
- Reset mid-word: send 2 bits, assert rst -> idx=0, word_valid=0, word_out=0, overrun=0. Then send 1,0,1,1 -> word_out=4'b1101.
- Streaming: bit_valid held at 1, word_ready=1, bits 0,1,1,0, 1,1,1,1 -> word_out=4'b0110 then 4'b1111, each with word_valid high for exactly 1 cycle and N cycles apart, overrun=0.
- Backpressure drop: word_ready=0; send 1,0,0,0 then 0,1,0,1 -> word_out stays 4'b0001 with word_valid=1, overrun=1. Then clr_overrun=1 -> overrun=0.
- Simultaneous consume and complete: word_valid=1 and word_ready=1 on the edge that accepts the 4th bit of 4'b1010 -> word_out=4'b1010, word_valid stays 1, overrun=0.
- Sync resync: send 1,1 then sync+bit_valid with bit 0, then 0,1,0 -> word_out=4'b0100 and idx=0 afterwards. sync alone after 3 bits -> idx=0 and no word is emitted.
- Idle gaps: bits separated by random bit_valid=0 cycles -> the same words as the gapless case. The per-edge idx sequence is 1,2,3,0 on each accept, and idx holds between accepts.
